// File: rtl/aes_encipher.sv
// AES-128 encipher datapath: 10 rounds, one shared 32-bit S-box word per cycle, round keys from aes_key_gen.
// Latency 50 cycles from accepting next to ready; next is ignored while busy (no queuing).
module aes_encipher (
   input  logic         clk,
   input  logic         reset,
   input  logic         next,
   input  logic         key_ready,
   input  logic [127:0] block,
   output logic [3:0]   round,
   input  logic [127:0] round_key,
   output logic [31:0]  sboxw,
   input  logic [31:0]  new_sboxw,
   output logic [127:0] new_block,
   output logic         ready
);

   typedef enum logic [1:0] {IDLE, SBOX, UPDATE} fsm_t;

   fsm_t         r_fsm;
   logic [127:0] r_state;
   logic [127:0] r_new_block;
   logic [3:0]   r_round;
   logic [1:0]   r_word;
   logic         r_ready;

   logic [127:0] w_shifted;
   logic [127:0] w_mixed;
   logic [31:0]  w_sboxw;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] mix_col(input logic [31:0] w);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = w;
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   // Byte (row r, column c) is taken from column (c + r) mod 4 of the same row.
   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
      return o;
   endfunction

   assign w_shifted = shift_rows(r_state);
   assign w_mixed   = {mix_col(w_shifted[127:96]), mix_col(w_shifted[95:64]),
                       mix_col(w_shifted[63:32]),  mix_col(w_shifted[31:0])};

   always_comb begin
      w_sboxw = r_state[127:96];
      case (r_word)
         2'd1:    w_sboxw = r_state[95:64];
         2'd2:    w_sboxw = r_state[63:32];
         2'd3:    w_sboxw = r_state[31:0];
         default: w_sboxw = r_state[127:96];
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_fsm       <= IDLE;
         r_state     <= '0;
         r_new_block <= '0;
         r_round     <= '0;
         r_word      <= '0;
         r_ready     <= 1'b1;
      end else begin
         case (r_fsm)
            IDLE: begin
               if (next && key_ready) begin
                  r_state <= block ^ round_key;
                  r_round <= 4'd1;
                  r_word  <= 2'd0;
                  r_ready <= 1'b0;
                  r_fsm   <= SBOX;
               end
            end
            SBOX: begin
               case (r_word)
                  2'd0:    r_state[127:96] <= new_sboxw;
                  2'd1:    r_state[95:64]  <= new_sboxw;
                  2'd2:    r_state[63:32]  <= new_sboxw;
                  default: r_state[31:0]   <= new_sboxw;
               endcase
               r_word <= r_word + 2'd1;
               if (r_word == 2'd3)
                  r_fsm <= UPDATE;
            end
            UPDATE: begin
               r_word <= 2'd0;
               // The final round skips MixColumns and publishes the result.
               if (r_round == 4'd10) begin
                  r_new_block <= w_shifted ^ round_key;
                  r_ready     <= 1'b1;
                  r_round     <= 4'd0;
                  r_fsm       <= IDLE;
               end else begin
                  r_state <= w_mixed ^ round_key;
                  r_round <= r_round + 4'd1;
                  r_fsm   <= SBOX;
               end
            end
            default: r_fsm <= IDLE;
         endcase
      end
   end

   assign round     = r_round;
   assign sboxw     = w_sboxw;
   assign new_block = r_new_block;
   assign ready     = r_ready;

endmodule
